// File: rtl/nfifo2mem_sched_pkg.sv
// Shared types and width helpers for the NFIFO2MEM read scheduler.
package nfifo2mem_sched_pkg;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   localparam int unsigned DEF_FLOWS       = 4;
   localparam int unsigned DEF_BURST       = 8;
   localparam int unsigned DEF_MEM_LATENCY = 1;

   // Ceiling log2; log2(1) = 0.
   function automatic int unsigned log2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned addr_w(input int unsigned flows);
      return log2(flows);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned burst);
      return log2(burst) + 1;
   endfunction

   localparam int unsigned DEF_AW = addr_w(DEF_FLOWS);
   localparam int unsigned DEF_CW = cnt_w(DEF_BURST);

endpackage

// File: rtl/nfifo2mem_rr_arb.sv
// Combinational rotating-priority arbiter: the search starts at ptr+1 and wraps,
// so the flow held in ptr is considered last.
module nfifo2mem_rr_arb #(
   parameter int unsigned FLOWS = 4,
   parameter int unsigned AW    = 2
) (
   input  logic [FLOWS-1:0] req,
   input  logic [AW-1:0]    ptr,
   output logic [AW-1:0]    gnt_idx,
   output logic             gnt_vld
);

   logic [AW-1:0] w_idx;

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      w_idx   = '0;
      for (int unsigned i = 1; i <= FLOWS; i++) begin
         w_idx = ptr + AW'(i);
         if (!gnt_vld && req[w_idx]) begin
            gnt_idx = w_idx;
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nfifo2mem_rd_sched.sv
// Round-robin burst read scheduler for the shared NFIFO2MEM memory, with a
// flow tag delayed to line up with the memory read latency.
module nfifo2mem_rd_sched
   import nfifo2mem_sched_pkg::*;
#(
   parameter  int unsigned FLOWS       = DEF_FLOWS,
   parameter  int unsigned BURST       = DEF_BURST,
   parameter  int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
   localparam int unsigned AW          = addr_w(FLOWS),
   localparam int unsigned CW          = cnt_w(BURST)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [FLOWS-1:0] EMPTY,
   input  logic [FLOWS-1:0] MASK,
   input  logic             DST_RDY,
   output logic             READ,
   output logic [AW-1:0]    BLOCK_ADDR,
   output logic             TAG_VLD,
   output logic [AW-1:0]    TAG,
   output logic             BUSY
);

   state_t                 r_state, w_next_state;
   logic [AW-1:0]          r_ptr, r_addr;
   logic [CW-1:0]          r_cnt;
   logic [FLOWS-1:0]       w_req;
   logic [AW-1:0]          w_gnt_idx;
   logic                   w_gnt_vld;
   logic                   w_read;
   logic                   w_burst_end;
   logic [MEM_LATENCY-1:0] r_tag_vld;
   logic [AW-1:0]          r_tag [MEM_LATENCY];

   assign w_req = ~EMPTY & MASK;

   nfifo2mem_rr_arb #(
      .FLOWS (FLOWS),
      .AW    (AW)
   ) u_arb (
      .req     (w_req),
      .ptr     (r_ptr),
      .gnt_idx (w_gnt_idx),
      .gnt_vld (w_gnt_vld)
   );

   always_comb begin
      w_next_state = r_state;
      w_read       = 1'b0;
      w_burst_end  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_gnt_vld) w_next_state = S_BURST;
         end
         S_BURST: begin
            w_read      = DST_RDY & ~EMPTY[r_addr] & MASK[r_addr];
            w_burst_end = (w_read && (r_cnt == CW'(BURST - 1))) ||
                          EMPTY[r_addr] || !MASK[r_addr];
            if (w_burst_end) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_ptr   <= AW'(FLOWS - 1);
         r_addr  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_IDLE && w_gnt_vld) begin
            r_addr <= w_gnt_idx;
            r_ptr  <= w_gnt_idx;
            r_cnt  <= '0;
         end else if (w_read) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Free-running tag pipe: never stalls, and reset discards reads in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_tag_vld <= '0;
         for (int unsigned k = 0; k < MEM_LATENCY; k++) r_tag[k] <= '0;
      end else begin
         r_tag_vld[0] <= w_read;
         r_tag[0]     <= r_addr;
         for (int unsigned k = 1; k < MEM_LATENCY; k++) begin
            r_tag_vld[k] <= r_tag_vld[k-1];
            r_tag[k]     <= r_tag[k-1];
         end
      end
   end

   assign READ       = w_read;
   assign BLOCK_ADDR = r_addr;
   assign BUSY       = (r_state == S_BURST);
   assign TAG_VLD    = r_tag_vld[MEM_LATENCY-1];
   assign TAG        = r_tag[MEM_LATENCY-1];

endmodule
